wfunc_apb_loader: RTL and testbench

WFUNC_APB_LOADER -- requirements
Module: wfunc_apb_loader

---
 rtl/wfunc_pkg.sv | 23 ++
 rtl/wfunc_apb_loader_apb_xfer.sv | 46 ++++
 rtl/wfunc_apb_loader.sv | 204 ++++++++++++++++++++
 tb/tb_wfunc_apb_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfunc_pkg.sv
// rtl/wfunc_pkg.sv - Register map and encodings shared with the window_func slave.
package wfunc_pkg;

    localparam int CTRL_SRST_BIT    = 0;
    localparam int CTRL_CHSTATE_BIT = 8;

    localparam int STATUS_STATE_MSB = 9;
    localparam int STATUS_STATE_LSB = 8;

    localparam logic [1:0] SLV_IDLE = 2'd0;
    localparam logic [1:0] SLV_WAIT = 2'd1;
    localparam logic [1:0] SLV_BUSY = 2'd2;

    // Control and status registers sit directly above the coefficient window.
    function automatic int ctrl_offset(input int fft_size);
        return fft_size * 4;
    endfunction

    function automatic int status_offset(input int fft_size);
        return (fft_size + 1) * 4;
    endfunction

endpackage

// File: rtl/wfunc_apb_loader_apb_xfer.sv
// rtl/wfunc_apb_loader_apb_xfer.sv - Single APB SETUP/ACCESS transfer engine, zero wait states.
module apb_xfer #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic          write,
    input  logic [31:0]   wdata,
    output logic          ack,
    output logic [31:0]   rdata,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [31:0]   pwdata,
    input  logic [31:0]   prdata
);

    // A new request is accepted when idle or in ACCESS, giving back-to-back transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else if (req && (!psel || penable)) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= write;
            paddr   <= addr;
            pwdata  <= wdata;
        end else if (psel && !penable) begin
            penable <= 1'b1;
        end else begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

    assign ack   = psel & penable;
    assign rdata = prdata;

endmodule

// File: rtl/wfunc_apb_loader.sv
// rtl/wfunc_apb_loader.sv - Streams window coefficients into a window_func slave over APB and arms it.
module wfunc_apb_loader #(
    parameter int FFT_SIZE = 8192,
    parameter int APB_AW   = $clog2(FFT_SIZE - 1) + 3,
    parameter int POLL_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              coef_tvalid,
    output logic              coef_tready,
    input  logic [31:0]       coef_tdata,
    input  logic              coef_tlast,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [APB_AW-1:0] paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        slv_state
);
    import wfunc_pkg::*;

    localparam int IW  = $clog2(FFT_SIZE);
    localparam int PCW = $clog2(POLL_MAX + 1);

    localparam logic [IW-1:0]     IDX_MAX     = IW'(FFT_SIZE - 1);
    localparam logic [PCW-1:0]    POLL_LAST   = PCW'(POLL_MAX - 1);
    localparam logic [APB_AW-1:0] CTRL_ADDR   = APB_AW'(ctrl_offset(FFT_SIZE));
    localparam logic [APB_AW-1:0] STATUS_ADDR = APB_AW'(status_offset(FFT_SIZE));

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SRST  = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_ARM   = 3'd4;
    localparam logic [2:0] ST_POLL  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERROR = 3'd7;

    logic [2:0]        state;
    logic [IW-1:0]     index;
    logic              last_q;
    logic [PCW-1:0]    poll_cnt;

    logic              req;
    logic [APB_AW-1:0] req_addr;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic              ack;
    logic [31:0]       rdata;

    logic              last_ok;
    logic              write_err;
    logic [1:0]        poll_state;
    logic              poll_wait;
    logic              poll_exhausted;
    logic              unused_rdata;

    apb_xfer #(.AW(APB_AW)) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .addr    (req_addr),
        .write   (req_write),
        .wdata   (req_wdata),
        .ack     (ack),
        .rdata   (rdata),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata)
    );

    // The window must end exactly on its last slot; tlast anywhere else is a framing error.
    assign last_ok        = (index == IDX_MAX) && last_q;
    assign write_err      = (index == IDX_MAX) ^ last_q;
    assign poll_state     = rdata[STATUS_STATE_MSB:STATUS_STATE_LSB];
    assign poll_wait      = (poll_state == SLV_WAIT);
    assign poll_exhausted = (poll_cnt == POLL_LAST);
    assign unused_rdata   = ^{rdata[31:STATUS_STATE_MSB+1], rdata[STATUS_STATE_LSB-1:0]};

    assign coef_tready = (state == ST_FETCH) && !rst;
    assign busy        = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign done        = (state == ST_DONE);

    // Transfers are launched on entry to the state that owns them, so SETUP follows immediately.
    always_comb begin
        req       = 1'b0;
        req_addr  = CTRL_ADDR;
        req_write = 1'b1;
        req_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    req       = 1'b1;
                    req_wdata = 32'h1 << CTRL_SRST_BIT;
                end
            end
            ST_FETCH: begin
                if (coef_tvalid) begin
                    req       = 1'b1;
                    req_addr  = APB_AW'({index, 2'b00});
                    req_wdata = coef_tdata;
                end
            end
            ST_WRITE: begin
                if (ack && last_ok) begin
                    req       = 1'b1;
                    req_wdata = 32'h1 << CTRL_CHSTATE_BIT;
                end
            end
            ST_ARM: begin
                if (ack) begin
                    req       = 1'b1;
                    req_write = 1'b0;
                    req_addr  = STATUS_ADDR;
                end
            end
            ST_POLL: begin
                if (ack && !poll_wait && !poll_exhausted) begin
                    req       = 1'b1;
                    req_write = 1'b0;
                    req_addr  = STATUS_ADDR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            index     <= '0;
            last_q    <= 1'b0;
            poll_cnt  <= '0;
            err       <= 1'b0;
            slv_state <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SRST;
                        err   <= 1'b0;
                    end
                end
                ST_SRST: begin
                    if (ack) begin
                        state <= ST_FETCH;
                        index <= '0;
                    end
                end
                ST_FETCH: begin
                    if (coef_tvalid) begin
                        last_q <= coef_tlast;
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (ack) begin
                        if (index != IDX_MAX) begin
                            index <= index + 1'b1;
                        end
                        if (last_ok) begin
                            state <= ST_ARM;
                        end else if (write_err) begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_ARM: begin
                    if (ack) begin
                        state    <= ST_POLL;
                        poll_cnt <= '0;
                    end
                end
                ST_POLL: begin
                    if (ack) begin
                        slv_state <= poll_state;
                        if (poll_wait) begin
                            state <= ST_DONE;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            if (poll_exhausted) begin
                                state <= ST_ERROR;
                                err   <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wfunc_apb_loader.sv
// tb/tb_wfunc_apb_loader.sv - Scoreboard bench for wfunc_apb_loader against a window_func slave model.
module tb_wfunc_apb_loader;
    localparam int N    = 16;
    localparam int PMAX = 4;
    localparam int AW   = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, coef_tvalid, coef_tready, coef_tlast;
    logic [31:0]   coef_tdata, pwdata, prdata;
    logic          psel, penable, pwrite, busy, done, err;
    logic [AW-1:0] paddr;
    logic [1:0]    slv_state;

    wfunc_apb_loader #(.FFT_SIZE(N), .POLL_MAX(PMAX)) dut (
        .clk(clk), .rst(rst), .start(start),
        .coef_tvalid(coef_tvalid), .coef_tready(coef_tready),
        .coef_tdata(coef_tdata), .coef_tlast(coef_tlast),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata),
        .busy(busy), .done(done), .err(err), .slv_state(slv_state)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } xfer_t;

    xfer_t       exp_q[$];
    xfer_t       mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] beat_data [N];
    bit          beat_last [N];
    logic [1:0]  model_slv = 2'b00;
    bit          abort_drv = 1'b0;

    // Slave: coefficient memory plus a scripted sequence of status states.
    logic [31:0] mem [N];
    int          rd_cnt = 0;
    int          rd_base = 0;
    logic [1:0]  resp_st [8];
    int          resp_len = 0;
    logic [1:0]  resp_dflt = 2'b10;
    logic [31:0] noise = 32'h0;

    assign prdata = {noise[31:10],
                     ((rd_cnt - rd_base) < resp_len) ? resp_st[rd_cnt - rd_base] : resp_dflt,
                     noise[7:0]};

    always @(posedge clk) begin
        if (psel && penable) begin
            if (pwrite && paddr < 7'h40) mem[paddr[5:2]] <= pwdata;
            if (!pwrite && paddr == 7'h44) rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [1:0] resp_of(input int k);
        return (k < resp_len) ? resp_st[k] : resp_dflt;
    endfunction

    // Monitor: every ACCESS must match the next expected transfer and hold its SETUP values.
    logic [AW-1:0] su_addr;
    logic [31:0]   su_data;
    logic          su_wr;
    always @(negedge clk) begin
        if (psel && !penable) begin
            su_addr = paddr;
            su_data = pwdata;
            su_wr   = pwrite;
        end
        if (psel && penable) begin
            check("hold_addr", 32'(paddr), 32'(su_addr));
            check("hold_dir", 32'(pwrite), 32'(su_wr));
            if (pwrite) check("hold_wdata", pwdata, su_data);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_xfer: got addr %h wr %0d data %h, required none", paddr, pwrite, pwdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("xfer_addr", 32'(paddr), 32'(mon_e.addr));
                check("xfer_dir", 32'(pwrite), 32'(mon_e.wr));
                if (mon_e.wr) check("xfer_wdata", pwdata, mon_e.data);
            end
        end
    end

    task automatic push_x(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data);
        xfer_t x;
        x.wr = wr;
        x.addr = addr;
        x.data = data;
        exp_q.push_back(x);
    endtask

    // Reference: control reset, beats until tlast or window end, then arm and poll if framed correctly.
    task automatic build_expect(output int nb, output bit exp_done);
        bit ok = 1'b0;
        nb = 0;
        exp_done = 1'b0;
        push_x(1'b1, 7'h40, 32'h1);
        for (int i = 0; i < N; i++) begin
            push_x(1'b1, 7'(i * 4), beat_data[i]);
            nb = i + 1;
            if (beat_last[i] || i == N - 1) begin
                ok = beat_last[i] && (i == N - 1);
                break;
            end
        end
        if (ok) begin
            push_x(1'b1, 7'h40, 32'h100);
            for (int k = 0; k < PMAX; k++) begin
                push_x(1'b0, 7'h44, 32'h0);
                model_slv = resp_of(k);
                if (model_slv == 2'b01) begin
                    exp_done = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic set_beats(input int last_pos);
        for (int i = 0; i < N; i++) begin
            beat_data[i] = $urandom;
            beat_last[i] = (i == last_pos);
        end
    endtask

    task automatic set_resp(input int len, input logic [1:0] s0, input logic [1:0] s1,
                            input logic [1:0] s2, input logic [1:0] dflt);
        resp_len = len;
        resp_st[0] = s0;
        resp_st[1] = s1;
        resp_st[2] = s2;
        resp_dflt = dflt;
        rd_base = rd_cnt;
        noise = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"}, 32'(psel), 0);
        check({tag, "_penable"}, 32'(penable), 0);
        check({tag, "_pwrite"}, 32'(pwrite), 0);
        check({tag, "_paddr"}, 32'(paddr), 0);
        check({tag, "_pwdata"}, pwdata, 0);
        check({tag, "_tready"}, 32'(coef_tready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_slv_state"}, 32'(slv_state), 0);
    endtask

    // vmode: 0 always valid, 1 toggling 1-0, 2 random.
    task automatic drive_beats(input int nb, input int vmode);
        int i = 0;
        bit hs;
        for (int c = 0; c < 800 && i < nb && !abort_drv; c++) begin
            coef_tdata  = beat_data[i];
            coef_tlast  = beat_last[i];
            coef_tvalid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c[0] == 1'b0) : ($urandom_range(0, 1) == 1);
            #1;
            hs = coef_tvalid && coef_tready;
            @(negedge clk);
            if (hs) i++;
        end
        coef_tvalid = 1'b0;
        coef_tlast  = 1'b0;
        if (!abort_drv) check("beats_accepted", i, nb);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic run_load(input int vmode, input bit extra_start);
        int nb;
        bit exp_done;
        bit seen_done = 1'b0;
        bit seen_err = 1'b0;
        abort_drv = 1'b0;
        build_expect(nb, exp_done);
        pulse_start();
        fork
            drive_beats(nb, vmode);
            begin
                for (int c = 0; c < 600; c++) begin
                    @(negedge clk);
                    if (done || err) begin
                        seen_done = done;
                        seen_err  = err;
                        break;
                    end
                    start = extra_start && (c == 5 || c == 30) && busy;
                end
                start = 1'b0;
            end
        join
        check("done_seen", 32'(seen_done), 32'(exp_done));
        check("err_seen", 32'(seen_err), 32'(!exp_done));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("busy_end", 32'(busy), 0);
        check("err_level", 32'(err), 32'(!exp_done));
        check("slv_state", 32'(slv_state), 32'(model_slv));
        check("pending_xfers", exp_q.size(), 0);
        for (int i = 0; i < nb; i++) check("window_mem", mem[i], beat_data[i]);
        exp_q.delete();
    endtask

    task automatic run_reset_abort();
        int nb;
        bit exp_done;
        int wr_n = 0;
        bit hit = 1'b0;
        abort_drv = 1'b0;
        build_expect(nb, exp_done);
        pulse_start();
        fork
            drive_beats(nb, 0);
            begin
                for (int c = 0; c < 300 && !hit; c++) begin
                    @(negedge clk);
                    if (psel && penable && pwrite) begin
                        wr_n++;
                        if (wr_n == 7) begin
                            rst = 1'b1;
                            hit = 1'b1;
                        end
                    end
                end
                abort_drv = 1'b1;
                @(negedge clk);
                check_reset_outputs("mid_rst");
                rst = 1'b0;
            end
        join
        check("rst_in_access7", 32'(hit), 1);
        exp_q.delete();
        model_slv = 2'b00;
        abort_drv = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        coef_tvalid = 1'b0;
        coef_tdata = 32'h0;
        coef_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < N; i++) begin
            beat_data[i] = i * 32'h00010001;
            beat_last[i] = (i == N - 1);
        end
        set_resp(1, 2'b01, 2'b00, 2'b00, 2'b10);
        run_load(0, 1'b0);

        set_beats(N - 1);
        set_resp(3, 2'b10, 2'b10, 2'b01, 2'b10);
        run_load(1, 1'b0);

        set_beats(4);
        set_resp(1, 2'b01, 2'b00, 2'b00, 2'b10);
        run_load(0, 1'b0);

        set_beats(N - 1);
        set_resp(0, 2'b00, 2'b00, 2'b00, 2'b00);
        run_load(2, 1'b0);

        set_beats(N);
        run_load(0, 1'b0);

        set_beats(N - 1);
        set_resp(2, 2'b00, 2'b01, 2'b00, 2'b10);
        run_load(0, 1'b1);

        set_beats(N - 1);
        set_resp(1, 2'b01, 2'b00, 2'b00, 2'b10);
        run_reset_abort();
        set_beats(N - 1);
        set_resp(2, 2'b10, 2'b01, 2'b00, 2'b10);
        run_load(2, 1'b0);

        for (int r = 0; r < 5; r++) begin
            set_beats(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : N - 1);
            set_resp(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            run_load(int'($urandom_range(0, 2)), r[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
